// File: rtl/cdc_req_pkg.sv
`timescale 1ns/1ps
// Shared state encoding and default sizing for the req/ack transmit crossing.
package cdc_req_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ_HI,
        REQ_LO
    } req_state_t;

    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_CNT_W       = 4;

endpackage

// File: rtl/cdc_req_tx_sync_chain.sv
`timescale 1ns/1ps
// Multi-flop synchronizer for a single asynchronous level; clears to 0 on reset.
module sync_chain
    import cdc_req_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_req_tx.sv
`timescale 1ns/1ps
// Four-phase req/ack transmitter: queues local event pulses, one handshake per event.
// Optional phase timeout flag enabled by defining CDC_REQ_TX_TIMEOUT_EN.
module cdc_req_tx
    import cdc_req_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int unsigned CNT_W          = DEF_CNT_W,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic             ack_async,
    output logic             req_out,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
`ifdef CDC_REQ_TX_TIMEOUT_EN
    ,
    output logic             timeout_err
`endif
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("cdc_req_tx: SYNC_STAGES must be in 2..4");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("cdc_req_tx: TIMEOUT_CYCLES must be at least 1");
    end

    req_state_t       state_q, state_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic             req_q, req_d;
    logic             ovf_q, ovf_d;
    logic             ack_s;
    logic             start;
    logic             inc;
    logic             sat;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk(clk),
        .rst(rst),
        .d_i(ack_async),
        .q_o(ack_s)
    );

    // IDLE->REQ_HI is gated by ack_s=0 so a stale far-end ack cannot complete a new request.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending_q != '0 && !ack_s) begin
                    state_d = REQ_HI;
                    start   = 1'b1;
                end
            end
            REQ_HI: begin
                if (ack_s) begin
                    state_d = REQ_LO;
                end
            end
            REQ_LO: begin
                if (!ack_s) begin
                    if (pending_q != '0) begin
                        state_d = REQ_HI;
                        start   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A full queue still accepts an event in the cycle a handshake draws one out.
    always_comb begin
        sat       = (pending_q == '1);
        inc       = pulse_in && (!sat || start);
        ovf_d     = pulse_in && sat && !start;
        pending_d = pending_q;
        if (inc && !start) begin
            pending_d = pending_q + CNT_W'(1);
        end else if (!inc && start) begin
            pending_d = pending_q - CNT_W'(1);
        end
        req_d = (state_d == REQ_HI);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            req_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            req_q     <= req_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef CDC_REQ_TX_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] phase_q, phase_d;
    logic            err_q, err_d;

    // Observation only: the handshake keeps waiting after the flag sets.
    always_comb begin
        phase_d = phase_q;
        if (state_d != state_q) begin
            phase_d = '0;
        end else if (state_q != IDLE && phase_q != TO_LIM) begin
            phase_d = phase_q + TO_W'(1);
        end
        err_d = err_q || (phase_d == TO_LIM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
            err_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            err_q   <= err_d;
        end
    end

    assign timeout_err = err_q;
`endif

    assign req_out  = req_q;
    assign pending  = pending_q;
    assign overflow = ovf_q;
    assign busy     = (state_q != IDLE) || (pending_q != '0);

endmodule

// File: tb/tb_cdc_req_tx.sv
`timescale 1ns/100ps
// Self-checking bench for cdc_req_tx with a modelled far-end responder.
module tb_cdc_req_tx;

    localparam int unsigned SS  = 2;
    localparam int unsigned CW  = 4;
    localparam int unsigned CW2 = 2;

    logic          clk = 1'b0;
    logic          fclk = 1'b0;
    logic          rst = 1'b1;
    logic          pulse = 1'b1;
    logic          pulse2 = 1'b0;
    logic          ack_force = 1'b1;
    logic          far_en = 1'b1;
    logic [2:0]    far_sh = '0;
    logic          ack_async;
    logic          req_out, busy, overflow;
    logic [CW-1:0] pending;
    logic          req2, busy2, ovf2;
    logic [CW2-1:0] pend2;
`ifdef CDC_REQ_TX_TIMEOUT_EN
    logic          terr, terr2;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int rises    = 0;
    int peak     = 0;
    int ev_id    = 0;
    int sb[$];

    logic [SS-1:0] acks_m = '0;
    logic          req_prev = 1'b0, acks_prev = 1'b0, rst_prev = 1'b1;

    always #5 clk = ~clk;

    // Far clock posedges land on half-ns points, never on a local edge.
    initial begin
        #1.5;
        forever begin
            fclk = 1'b1;
            #3;
            fclk = 1'b0;
            #4;
        end
    end

    always @(posedge fclk) far_sh <= {far_sh[1:0], req_out};
    assign ack_async = (far_en & far_sh[2]) | ack_force;

    always @(posedge clk) begin
        if (rst) acks_m <= '0;
        else     acks_m <= {acks_m[SS-2:0], ack_async};
    end

    cdc_req_tx #(
        .SYNC_STAGES(SS),
        .CNT_W(CW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pulse_in(pulse),
        .ack_async(ack_async),
        .req_out(req_out),
        .busy(busy),
        .pending(pending),
        .overflow(overflow)
`ifdef CDC_REQ_TX_TIMEOUT_EN
        ,
        .timeout_err(terr)
`endif
    );

    cdc_req_tx #(
        .SYNC_STAGES(SS),
        .CNT_W(CW2),
        .TIMEOUT_CYCLES(8)
    ) dut2 (
        .clk(clk),
        .rst(rst),
        .pulse_in(pulse2),
        .ack_async(ack_force),
        .req_out(req2),
        .busy(busy2),
        .pending(pend2),
        .overflow(ovf2)
`ifdef CDC_REQ_TX_TIMEOUT_EN
        ,
        .timeout_err(terr2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Protocol monitor: every req rise consumes a queued event and follows ack_s low.
    always @(negedge clk) begin
        if (!rst && !rst_prev) begin
            if (req_out && !req_prev) begin
                rises++;
                check("rise_after_ack_low", acks_prev, 0);
                check("rise_has_event", sb.size() != 0, 1);
                if (sb.size() != 0) void'(sb.pop_front());
            end
            if (req_prev && acks_prev) check("req_fall_after_ack", req_out, 0);
            if (req_prev && !acks_prev) check("req_hold_until_ack", req_out, 1);
            if (int'(pending) > peak) peak = int'(pending);
        end
        req_prev  = req_out;
        acks_prev = acks_m[SS-1];
        rst_prev  = rst;
    end

    task automatic drive_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            pulse = 1'b1;
            sb.push_back(ev_id++);
        end
        @(posedge clk); #1;
        pulse = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (!busy && !req_out && sb.size() == 0 && !acks_m[SS-1]) done = 1'b1;
        end
        check(tag, done, 1);
    endtask

    task automatic wait_acks(input logic lvl, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (acks_m[SS-1] == lvl) seen = 1'b1;
        end
    endtask

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        logic [CW2-1:0] exp_p2 [7] = '{1, 1, 2, 3, 3, 3, 3};
        logic           exp_o2 [7] = '{0, 0, 0, 0, 1, 1, 0};

        // 1: reset dominates pulse and ack
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_req", req_out, 0);
            check("rst_pending", pending, 0);
            check("rst_busy", busy, 0);
        end
        @(posedge clk); #0.2;
        rst = 1'b0;
        pulse = 1'b0;
        ack_force = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_rst_quiet", {req_out, busy, overflow, pending}, 0);
            check("post_rst_quiet2", {req2, busy2, ovf2, pend2}, 0);
        end

        // 2: single event
        rises = 0;
        drive_pulses(1);
        check("single_pending1", pending, 1);
        check("single_req_not_yet", req_out, 0);
        @(posedge clk); #1;
        check("single_req_up", req_out, 1);
        check("single_pending0", pending, 0);
        wait_acks(1'b1, 60, seen);
        check("single_ack_rise_seen", seen, 1);
        wait_acks(1'b0, 60, seen);
        check("single_ack_fall_seen", seen, 1);
        check("single_busy_reqlo", busy, 1);
        @(negedge clk);
        check("single_busy_cleared", busy, 0);
        check("single_rises", rises, 1);

        // 3: burst of five
        rises = 0;
        peak = 0;
        drive_pulses(5);
        wait_idle("burst_done", 600);
        check("burst_peak", peak, 4);
        check("burst_rises", rises, 5);
        check("burst_final_pending", pending, 0);

        // stale ack high while idle holds off the next request
        rises = 0;
        ack_force = 1'b1;
        repeat (4) @(posedge clk);
        drive_pulses(1);
        repeat (5) @(posedge clk);
        #1;
        check("stale_ack_req_low", req_out, 0);
        check("stale_ack_pending", pending, 1);
        ack_force = 1'b0;
        wait_idle("stale_ack_done", 200);
        check("stale_ack_rises", rises, 1);

        // 4: saturation on the narrow counter, ack held low
        @(posedge clk); #1;
        pulse2 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            pulse2 = (i + 1 < 6);
            check($sformatf("ovf_pending_e%0d", i + 1), pend2, exp_p2[i]);
            check($sformatf("ovf_flag_e%0d", i + 1), ovf2, exp_o2[i]);
            check($sformatf("ovf_req_e%0d", i + 1), req2, (i >= 1));
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("ovf_rst_clears", {req2, busy2, pend2}, 0);

        // 5: reset mid-handshake with two queued
        drive_pulses(3);
        check("midrst_req_hi", req_out, 1);
        check("midrst_pending2", pending, 2);
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        check("midrst_req", req_out, 0);
        check("midrst_pending", pending, 0);
        check("midrst_idle", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_idle("midrst_settle", 100);

`ifdef CDC_REQ_TX_TIMEOUT_EN
        // 6: timeout flag with a silent far end
        far_en = 1'b0;
        drive_pulses(1);
        @(posedge clk); #1;
        check("to_req_up", req_out, 1);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            check($sformatf("to_err_c%0d", i), terr, (i == 8));
        end
        check("to_req_held", req_out, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("to_rst_clears", terr, 0);
        sb.delete();
        rst = 1'b0;
        far_en = 1'b1;
        repeat (3) @(posedge clk);
`endif

        check("sb_empty_end", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
